// File: rtl/wb_master_if.sv
// wishbone_if: Wishbone signal bundle without byte selects, shared by the
// initiator (wb_master) and the word-addressed RAM slave.
interface wishbone_if;
    logic        cycle;
    logic        strobe;
    logic        write_enable;
    logic        ack;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output cycle, strobe, write_enable, address, data_in,
        input  data_out, ack
    );

    modport slave (
        input  cycle, strobe, write_enable, address, data_in,
        output data_out, ack
    );
endinterface

// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone initiator for core loads/stores; sub-word
// stores become read-modify-write. Define WB_MASTER_TIMEOUT_EN for the ack timeout.
module wb_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    wishbone_if.master  wishbone
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_RMW_WR = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lo_q, lo_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tmo_hit;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'b11) || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
    endfunction

    // Little-endian lane insert of the store data into the word just read.
    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [15:0] wd,
                                                input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] w;
        w = old;
        if (size == SZ_BYTE) w[{lo, 3'b000} +: 8] = wd[7:0];
        else                 w[{lo[1], 4'b0000} +: 16] = wd;
        return w;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == TMO_LAST);
`else
    // Without the counter the bus waits for ack forever; TIMEOUT_CYCLES has no effect.
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_d = (cyc_q && !wishbone.ack) ? tmo_q + 32'd1 : tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lo_d    = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    adr_d   = {req_addr[31:2], 2'b00};
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_d = 32'd0;
`endif
                    if (misaligned(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_write) begin
                        cyc_d   = 1'b1;
                        state_d = S_RD;
                    end else if (req_size == SZ_WORD) begin
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        dat_d   = req_wdata;
                        state_d = S_WR;
                    end else begin
                        cyc_d   = 1'b1;
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
                if (wishbone.ack) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    if (state_q == S_RD)
                        rdata_d = extract_load(wishbone.data_out, size_q, lo_q, uns_q);
                    if (state_q == S_RMW_RD) begin
                        dat_d   = merge_store(wishbone.data_out, wdata_q, size_q, lo_q);
                        state_d = S_GAP;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (tmo_hit) begin
                    // Abandon the cycle; an RMW stopped here never reaches its write.
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = S_RESP;
                end
            end
            S_GAP: begin
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                state_d = S_RMW_WR;
`ifdef WB_MASTER_TIMEOUT_EN
                tmo_d = 32'd0;
`endif
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lo_q    <= 2'b00;
            wdata_q <= 16'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign wishbone.cycle        = cyc_q;
    assign wishbone.strobe       = cyc_q;
    assign wishbone.write_enable = we_q;
    assign wishbone.address      = adr_q;
    assign wishbone.data_in      = dat_q;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_error = rsp_valid & err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master: table of load/store vectors against a word RAM slave
// that acks two edges after strobe is first seen, plus reset/spurious-ack sequences.
module tb_wb_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int checks = 0;
    int errors = 0;

    wishbone_if wb();

    wb_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .wishbone     (wb)
    );

    always #5 clk = ~clk;

    // RAM slave: word addressed, ack two edges after strobe is first seen.
    logic [31:0] mem [0:255];
    logic        mem_ready = 1'b0;
    logic        seen = 1'b0;
    logic        ack_r = 1'b0;
    logic        no_ack = 1'b0;
    logic        spur_ack = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[8'h80] <= 32'h11223344;
            mem[8'hC0] <= 32'h80F07F01;
            mem_ready  <= 1'b1;
        end else if (wb.cycle && wb.strobe && !ack_r && !no_ack) begin
            if (seen) begin
                ack_r <= 1'b1;
                if (wb.write_enable) mem[wb.address[9:2]] <= wb.data_in;
            end else begin
                seen <= 1'b1;
            end
        end else begin
            ack_r <= 1'b0;
            seen  <= 1'b0;
        end
    end

    assign wb.ack      = ack_r | spur_ack;
    assign wb.data_out = mem[wb.address[9:2]];

    // Bus monitor: counts cycle starts, write cycles and idle-gap violations.
    int   cyc_rises = 0;
    int   wr_rises = 0;
    int   gap_bad = 0;
    int   low_run = 1;
    logic prev_cyc = 1'b0;

    always @(posedge clk) begin
        if (wb.cycle && !prev_cyc) begin
            cyc_rises = cyc_rises + 1;
            if (wb.write_enable) wr_rises = wr_rises + 1;
            if (low_run < 1) gap_bad = gap_bad + 1;
        end
        low_run  = wb.cycle ? 0 : low_run + 1;
        prev_cyc = wb.cycle;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // lat = clock edges from the accept edge to the edge that raises rsp_valid
    // (0 means the response is visible in the cycle right after accept; -1 = none).
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic pulse_ok);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; rd = 32'd0; er = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k - 1; rd = rsp_rdata; er = rsp_error;
                break;
            end
        end
        @(negedge clk);
        pulse_ok = !rsp_valid;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_cyc;
        int          exp_wr;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic un,
                                input logic [31:0] ad, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_err,
                                input int exp_lat, input int exp_cyc, input int exp_wr);
        vec_t v;
        v.wr = wr; v.sz = sz; v.un = un; v.ad = ad; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_cyc = exp_cyc; v.exp_wr = exp_wr;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin : main
        logic [31:0] rd;
        logic        er;
        logic        pulse_ok;
        int          lat;
        int          c0, w0;

        //             wr    sz     un    addr          wdata         exp_rdata     err   lat cyc wr
        vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h00000000, 1'b0, 3, 1, 1);
        vecs[1]  = mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0);
        vecs[2]  = mk(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AA, 32'h00000000, 1'b0, 7, 2, 1);
        vecs[3]  = mk(1'b0, 2'b10, 1'b0, 32'h200, 32'h0,        32'h11AA3344, 1'b0, 3, 1, 0);
        vecs[4]  = mk(1'b0, 2'b00, 1'b0, 32'h302, 32'h0,        32'hFFFFFFF0, 1'b0, 3, 1, 0);
        vecs[5]  = mk(1'b0, 2'b00, 1'b1, 32'h302, 32'h0,        32'h000000F0, 1'b0, 3, 1, 0);
        vecs[6]  = mk(1'b0, 2'b01, 1'b0, 32'h302, 32'h0,        32'hFFFF80F0, 1'b0, 3, 1, 0);
        vecs[7]  = mk(1'b0, 2'b01, 1'b1, 32'h300, 32'h0,        32'h00007F01, 1'b0, 3, 1, 0);
        vecs[8]  = mk(1'b0, 2'b00, 1'b0, 32'h303, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0);
        vecs[9]  = mk(1'b0, 2'b01, 1'b0, 32'h101, 32'h0,        32'h00000000, 1'b1, 0, 0, 0);
        vecs[10] = mk(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 32'h00000000, 1'b1, 0, 0, 0);
        vecs[11] = mk(1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1, 0, 0, 0);
        vecs[12] = mk(1'b1, 2'b01, 1'b0, 32'h300, 32'hCAFE1234, 32'h00000000, 1'b0, 7, 2, 1);
        vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h300, 32'h0,        32'h80F01234, 1'b0, 3, 1, 0);
        vecs[14] = mk(1'b1, 2'b00, 1'b0, 32'h101, 32'h00000055, 32'h00000000, 1'b0, 7, 2, 1);
        vecs[15] = mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hDEAD55EF, 1'b0, 3, 1, 0);
        vecs[16] = mk(1'b0, 2'b01, 1'b0, 32'h300, 32'h0,        32'h00001234, 1'b0, 3, 1, 0);
        vecs[17] = mk(1'b0, 2'b00, 1'b1, 32'h301, 32'h0,        32'h00000012, 1'b0, 3, 1, 0);

        // Reset state while reset_n is still low.
        repeat (3) @(negedge clk);
        chk("rst_cycle", {31'd0, wb.cycle}, 32'd0);
        chk("rst_strobe", {31'd0, wb.strobe}, 32'd0);
        chk("rst_we", {31'd0, wb.write_enable}, 32'd0);
        chk("rst_address", wb.address, 32'd0);
        chk("rst_data_in", wb.data_in, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // ack while cycle is low must be ignored.
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        chk("spur_cycle", {31'd0, wb.cycle}, 32'd0);
        chk("spur_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("spur_req_ready", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            c0 = cyc_rises; w0 = wr_rises;
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].un, vecs[i].ad, vecs[i].wd, rd, er, lat, pulse_ok);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_error", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_one_pulse", i), {31'd0, pulse_ok}, 32'd1);
            chk($sformatf("v%0d_bus_cycles", i), 32'(cyc_rises - c0), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_write_cycles", i), 32'(wr_rises - w0), 32'(vecs[i].exp_wr));
        end

        // Reset in the middle of the RMW read cycle.
        c0 = cyc_rises; w0 = wr_rises;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h201; req_wdata = 32'h00000077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_cycle_high", {31'd0, wb.cycle}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_cycle", {31'd0, wb.cycle}, 32'd0);
        chk("mid_rst_strobe", {31'd0, wb.strobe}, 32'd0);
        chk("mid_rst_address", wb.address, 32'd0);
        pulse_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) pulse_ok = 1'b0;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) pulse_ok = 1'b0;
        end
        chk("mid_rst_no_rsp", {31'd0, pulse_ok}, 32'd1);
        chk("mid_rst_no_write", 32'(wr_rises - w0), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, er, lat, pulse_ok);
        chk("post_rst_rdata", rd, 32'h11AA3344);
        chk("post_rst_error", {31'd0, er}, 32'd0);
        chk("post_rst_latency", 32'(lat), 32'd3);

`ifdef WB_MASTER_TIMEOUT_EN
        // Slave never acks: cycle held for 8 cycles, then an error response.
        no_ack = 1'b1;
        c0 = cyc_rises; w0 = wr_rises;
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat, pulse_ok);
        chk("tmo_ld_rdata", rd, 32'd0);
        chk("tmo_ld_error", {31'd0, er}, 32'd1);
        chk("tmo_ld_latency", 32'(lat), 32'd8);
        chk("tmo_ld_cycle_low", {31'd0, wb.cycle}, 32'd0);
        c0 = cyc_rises; w0 = wr_rises;
        do_req(1'b1, 2'b00, 1'b0, 32'h200, 32'h00000099, rd, er, lat, pulse_ok);
        chk("tmo_rmw_error", {31'd0, er}, 32'd1);
        chk("tmo_rmw_latency", 32'(lat), 32'd8);
        chk("tmo_rmw_bus_cycles", 32'(cyc_rises - c0), 32'd1);
        chk("tmo_rmw_no_write", 32'(wr_rises - w0), 32'd0);
        no_ack = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, er, lat, pulse_ok);
        chk("tmo_after_rdata", rd, 32'h11AA3344);
        chk("tmo_after_error", {31'd0, er}, 32'd0);
`endif

        chk("idle_gap_between_cycles", 32'(gap_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/wb_master.md
# wb_master

Wishbone initiator that turns single load/store requests from the core's memory stage into Wishbone bus cycles on a `wishbone_if.master` port. It drives the same bus the word-addressed RAM slave responds on, and that bus has no byte selects. The block therefore performs sub-word stores as read-modify-write and extracts and extends sub-word loads itself. It sits between the core and the bus, with one outstanding transaction at a time.

## Interface
- `TIMEOUT_CYCLES`, default 256: cycles to wait for `ack` before aborting. Used only with `WB_MASTER_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: zero-extend when 1, sign-extend when 0.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  load result, extended to 32 bits; 0 for stores.
- `rsp_error`  out  1  valid with `rsp_valid`: misaligned access, illegal size, or timeout.
- `wishbone`  master  `wishbone_if`  bus signals:
  - outputs: `cycle`, `strobe`, `write_enable`, `address[31:0]`, `data_in[31:0]`;
  - input: `data_out[31:0]`, `ack`.

## Operation
- States: IDLE, RD, WR, RMW_RD, GAP, RMW_WR, RESP.
- IDLE:
  - `req_ready` = 1 only in IDLE.
  - On accept, latch all request fields.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) or size 11: go to RESP with error. No bus cycle is issued.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte/half store: go to RMW_RD.
- Bus cycle states:
  - `cycle`/`strobe` are high in RD, WR, RMW_RD and RMW_WR.
  - `write_enable` is high in WR and RMW_WR.
  - `address` = {req_addr[31:2], 2'b00}.
  - All bus outputs are registered and held stable until `ack` is sampled.
- On `ack` sampled high:
  - Deassert `cycle`/`strobe`/`write_enable` at that edge.
  - RD: capture `data_out` and go to RESP.
  - WR / RMW_WR: go to RESP.
  - RMW_RD: go to GAP.
- RMW_RD: capture `data_out` and merge in the store lanes into the write buffer, little-endian.
  - Byte store: lane addr[1:0] gets req_wdata[7:0].
  - Half store: lanes {addr[1],0} and {addr[1],1} get req_wdata[15:0].
  - Other lanes are unchanged.
- GAP: one cycle with `cycle` low, then RMW_WR with `data_in` = the merged word.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: bytes {addr[1],1}:{addr[1],0}.
  - Extend per `req_unsigned`.
- RESP: `rsp_valid` = 1 for exactly one cycle, then IDLE. `rsp_rdata`/`rsp_error` are valid only in this cycle.
- `ack` arriving while `cycle` is low is ignored.

## Timing
- Reset (async, `reset_n` low) forces the following immediately, regardless of state, including mid-cycle (the bus transaction is abandoned and no response is issued):
  - state IDLE;
  - `cycle`, `strobe`, `write_enable`, `rsp_valid`, `rsp_error` = 0;
  - `address`, `data_in`, `rsp_rdata` = 0;
  - `req_ready` = 1 once `reset_n` is high.
- Against the RAM slave (ack two edges after `strobe` is first seen), measured from the accept edge E:
  - `cycle` rises after E.
  - `ack` is sampled at E+3.
  - `rsp_valid` is high in the cycle after E+3.
- Latencies to `rsp_valid`:
  - load or word store: 3 cycles;
  - sub-word store: 7 cycles (RMW_RD 3 + GAP 1 + RMW_WR 3);
  - alignment error: 1 cycle.
- `cycle` is low for at least one full cycle between any two bus cycles: GAP inside RMW, and RESP/IDLE between requests.
- Back-to-back requests: the next accept can occur no earlier than the cycle after RESP.

## Configuration
- `WB_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entry to each bus state and increments every cycle `cycle` is high without `ack`.
  - When the counter reaches `TIMEOUT_CYCLES`, drop `cycle`/`strobe`/`write_enable` and go to RESP with `rsp_error` = 1 and `rsp_rdata` = 0.
  - An RMW that times out in RMW_RD performs no write.
- `WB_MASTER_TIMEOUT_EN` undefined:
  - No counter.
  - The block waits for `ack` indefinitely.
  - `rsp_error` is set only for alignment/size faults.

## Test plan
- Word store of 0xDEADBEEF to 0x100, then word load from 0x100 → `rsp_rdata` = 0xDEADBEEF, `rsp_error` = 0, each `rsp_valid` 3 cycles after accept.
- Word at 0x200 = 0x11223344; byte store 0xAA to 0x202 → exactly one read cycle, at least one idle cycle, then one write cycle; word load then returns 0x11AA3344; store latency is 7 cycles.
- Word at 0x300 = 0x80F07F01:
  - signed byte load from 0x302 → 0xFFFFFFF0;
  - unsigned byte load from 0x302 → 0x000000F0;
  - signed half load from 0x302 → 0xFFFF80F0.
- Half load from 0x101, and word store to 0x102 → `rsp_error` = 1 one cycle after accept; `cycle` never asserts.
- Assert `reset_n` low while `cycle` is high during RMW_RD → `cycle` = 0 immediately, no `rsp_valid`; after release a word load succeeds.
- With `WB_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, slave never acks → `cycle` drops after 8 cycles and `rsp_valid` with `rsp_error` = 1 follows.
